// File: rtl/scan_pkg.sv
// Shared definitions for the display scan sequencer and its neighbours
// (digit-data mux, frame counters).
package scan_pkg;

    localparam int N_DIGITS = 4;
    localparam int SEL_W    = 2;

    // Returns {wrap_flag, next_sel}. The search starts at sel+1 and ends at sel
    // itself, so a single enabled digit maps back onto itself.
    // wrap_flag is set when the scan comes back round (next <= current).
    // An all-zero mask holds sel and never reports a wrap.
    function automatic logic [SEL_W:0] next_active(
        input logic [SEL_W-1:0]    sel,
        input logic [N_DIGITS-1:0] mask
    );
        logic [SEL_W-1:0] nxt;
        logic [SEL_W-1:0] idx;
        logic             found;
        nxt   = sel;
        found = 1'b0;
        for (int i = 1; i <= N_DIGITS; i++) begin
            idx = sel + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        return {found && (nxt <= sel), nxt};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Dwell-time prescaler: emits a one-cycle advance strobe on the enabled
// edge where the counter reaches PRESCALE-1.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_o
);

    localparam int                CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The strobe is combinational so the owner of sel can register the
    // advance on the very edge that wraps the counter.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Multiplexed 4-digit display scanner: walks sel over the enabled digits
// in circular ascending order, one digit per PRESCALE-cycle dwell.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]    sel,
    output logic                tick,
    output logic                wrap,
    output logic                valid
);

    logic             advance;
    logic [SEL_W:0]   nxt;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap_q;
    logic             wrap_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .tick_o (advance)
    );

    // The mask only matters on the advance edge; tick and wrap are
    // cleared on every other edge, including frozen (en=0) ones.
    always_comb begin
        nxt    = next_active(sel_q, digit_mask);
        sel_d  = sel_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (advance) begin
            sel_d  = nxt[SEL_W-1:0];
            tick_d = 1'b1;
            wrap_d = nxt[SEL_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign sel   = sel_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
    // Blanks the display at once if the current digit is masked mid-dwell.
    assign valid = digit_mask[sel_q];

endmodule
